// File: rtl/cardinal_nic_buffered_if.sv
// Processor register port and router channel pair of one cardinal NIC, bundled
// so the NIC (slave) and its driver (master) share a single connection.
interface cardinal_nic_buffered_if #(
  parameter int DATA_W = 64
);
  logic [0:1]        addr;
  logic [0:DATA_W-1] d_in;
  logic [0:DATA_W-1] d_out;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_si;
  logic              net_ri;
  logic [0:DATA_W-1] net_di;
  logic              net_so;
  logic              net_ro;
  logic [0:DATA_W-1] net_do;
  logic              net_polarity;

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/cardinal_nic_buffered.sv
// Buffered NIC for one cardinal CMP node: a DEPTH-deep FIFO per direction between
// the memory-mapped processor port and the ring router, with polarity-gated injection.
module cardinal_nic_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [0:DATA_W-1] din_i,
  input  logic              pop_i,
  output logic [0:DATA_W-1] dout_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [0:DATA_W-1] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end
endmodule

module cardinal_nic_buffered #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input logic                     clk,
  input logic                     reset,
  cardinal_nic_buffered_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [0:DATA_W-1] ibuf_head_s, obuf_head_s;
  logic [CNT_W-1:0]  ibuf_count_s, obuf_count_s;
  logic              ibuf_full_s, ibuf_empty_s, obuf_full_s, obuf_empty_s;
  logic              ibuf_push_s, ibuf_pop_s, obuf_push_s, obuf_pop_s;
  logic              rd_s, wr_s;
  logic [0:DATA_W-1] d_out_s;

  // Status word: flag in the last bit, count zero-extended into the byte 8..15 from the end.
  function automatic logic [0:DATA_W-1] status_word(input logic flag, input logic [CNT_W-1:0] cnt);
    logic [7:0] cnt8;
    cnt8 = 8'h00;
    cnt8[CNT_W-1:0] = cnt;
    status_word = '0;
    status_word[DATA_W-16 +: 8] = cnt8;
    status_word[DATA_W-1] = flag;
  endfunction

  assign rd_s = bus.nicEn & ~bus.nicWrEn & ~reset;
  assign wr_s = bus.nicEn & bus.nicWrEn & ~reset;

  assign bus.net_ri  = ~reset & ~ibuf_full_s;
  assign ibuf_push_s = bus.net_si & bus.net_ri;
  assign ibuf_pop_s  = rd_s & (bus.addr == 2'b00) & ~ibuf_empty_s;

  // Bit 0 of the head packet is its VC; it may only leave in the matching ring phase.
  assign obuf_push_s = wr_s & (bus.addr == 2'b10) & ~obuf_full_s;
  assign bus.net_so  = ~reset & ~obuf_empty_s & bus.net_ro & (obuf_head_s[0] == bus.net_polarity);
  assign obuf_pop_s  = bus.net_so;
  assign bus.net_do  = obuf_head_s;

  cardinal_nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ibuf (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (ibuf_push_s),
    .din_i   (bus.net_di),
    .pop_i   (ibuf_pop_s),
    .dout_o  (ibuf_head_s),
    .count_o (ibuf_count_s),
    .full_o  (ibuf_full_s),
    .empty_o (ibuf_empty_s)
  );

  cardinal_nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_obuf (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (obuf_push_s),
    .din_i   (bus.d_in),
    .pop_i   (obuf_pop_s),
    .dout_o  (obuf_head_s),
    .count_o (obuf_count_s),
    .full_o  (obuf_full_s),
    .empty_o (obuf_empty_s)
  );

  always_comb begin
    d_out_s = '0;
    if (rd_s) begin
      case (bus.addr)
        2'b00:   d_out_s = ibuf_empty_s ? '0 : ibuf_head_s;
        2'b01:   d_out_s = status_word(~ibuf_empty_s, ibuf_count_s);
        2'b11:   d_out_s = status_word(obuf_full_s, obuf_count_s);
        default: d_out_s = '0;
      endcase
    end else begin
      d_out_s = '0;
    end
  end

  assign bus.d_out = d_out_s;
endmodule

// File: tb/tb_cardinal_nic_buffered.sv
// Scoreboard bench for cardinal_nic_buffered (DEPTH=4): expected packets are queued
// when driven and compared when the NIC hands them to the processor or the router.
module tb_cardinal_nic_buffered;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [63:0] ibuf_q[$];
  logic [63:0] obuf_q[$];
  logic [63:0] v;
  int   k;
  int   sent;

  cardinal_nic_buffered_if #(.DATA_W(DATA_W)) bus ();

  cardinal_nic_buffered #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic proc_write(input logic [1:0] a, input logic [63:0] d);
    bus.addr = a; bus.d_in = d; bus.nicEn = 1'b1; bus.nicWrEn = 1'b1;
    cycle();
    bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
  endtask

  task automatic proc_read(input logic [1:0] a, output logic [63:0] d);
    bus.addr = a; bus.nicEn = 1'b1; bus.nicWrEn = 1'b0;
    #1;
    d = bus.d_out;
    cycle();
    bus.nicEn = 1'b0;
  endtask

  initial begin
    bus.addr = 2'b00; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
    bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b1; bus.net_polarity = 1'b0;

    // Reset and idle
    bus.nicEn = 1'b1; bus.addr = 2'b01;
    cycle(); cycle();
    chk("rst_ri", bus.net_ri, 64'd0);
    chk("rst_so", bus.net_so, 64'd0);
    chk("rst_dout", bus.d_out, 64'd0);
    bus.nicEn = 1'b0;
    reset = 1'b0;
    #1;
    chk("idle_ri", bus.net_ri, 64'd1);
    chk("idle_so", bus.net_so, 64'd0);
    cycle();
    proc_read(2'b01, v); chk("idle_st01", v, 64'd0);
    proc_read(2'b11, v); chk("idle_st11", v, 64'd0);

    // Fill OBUF while the router is stalled, then drain in order
    bus.net_ro = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      proc_write(2'b10, 64'h0B00 + 64'(i));
      obuf_q.push_back(64'h0B00 + 64'(i));
    end
    proc_write(2'b10, 64'h0BFF);
    proc_read(2'b11, v); chk("full_st11", v, 64'h0401);
    chk("full_so", bus.net_so, 64'd0);
    bus.net_ro = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("drain_so", bus.net_so, 64'd1);
      chk("drain_do", bus.net_do, obuf_q.pop_front());
      cycle();
    end
    chk("drained_so", bus.net_so, 64'd0);
    proc_read(2'b11, v); chk("drained_st11", v, 64'd0);

    // Injection latency and one-per-cycle throughput
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        bus.addr = 2'b10; bus.d_in = 64'h0C00 + 64'(i); bus.nicEn = 1'b1; bus.nicWrEn = 1'b1;
      end else begin
        bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
      end
      #1;
      if (i == 0) begin
        chk("inj_nobypass", bus.net_so, 64'd0);
      end else begin
        chk("inj_so", bus.net_so, 64'd1);
        chk("inj_do", bus.net_do, obuf_q.pop_front());
      end
      if (i < 6) obuf_q.push_back(64'h0C00 + 64'(i));
      cycle();
    end
    chk("inj_idle_so", bus.net_so, 64'd0);

    // Polarity gating: VC bit 1 may only leave while polarity is 1, exactly once
    bus.net_ro = 1'b0;
    proc_write(2'b10, 64'h8000_0000_0000_00C1);
    bus.net_ro = 1'b1;
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      bus.net_polarity = i[0];
      #1;
      chk("pol_so", bus.net_so, 64'((bus.net_polarity == 1'b1) && (sent == 0)));
      if (bus.net_so) begin
        chk("pol_do", bus.net_do, 64'h8000_0000_0000_00C1);
        sent++;
      end
      cycle();
    end
    chk("pol_sent_once", 64'(sent), 64'd1);
    bus.net_polarity = 1'b0;

    // Receive flow control: fifth packet is held until the processor pops
    bus.net_si = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.net_di = 64'hA0 + 64'(k);
      #1;
      chk("rx_ri", bus.net_ri, 64'(k < DEPTH));
      if (bus.net_ri) begin
        ibuf_q.push_back(bus.net_di);
        k++;
      end
      cycle();
    end
    bus.addr = 2'b00; bus.nicEn = 1'b1; bus.nicWrEn = 1'b0;
    #1;
    chk("rx_full_ri", bus.net_ri, 64'd0);
    chk("rx_rd_head", bus.d_out, ibuf_q.pop_front());
    cycle();
    bus.nicEn = 1'b0;
    #1;
    chk("rx_ri_reopen", bus.net_ri, 64'd1);
    ibuf_q.push_back(bus.net_di);
    cycle();
    bus.net_si = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      proc_read(2'b00, v); chk("rx_rd", v, ibuf_q.pop_front());
    end
    proc_read(2'b00, v); chk("rx_rd_empty", v, 64'd0);

    // Read of empty IBUF in the same cycle as a network push
    bus.net_si = 1'b1; bus.net_di = 64'h00D0;
    bus.addr = 2'b00; bus.nicEn = 1'b1; bus.nicWrEn = 1'b0;
    #1;
    chk("rd_push_dout", bus.d_out, 64'd0);
    cycle();
    bus.net_si = 1'b0; bus.nicEn = 1'b0;
    proc_read(2'b00, v); chk("rd_push_later", v, 64'h00D0);

    // Wrap-around with push and pop every cycle
    bus.net_si = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.net_di = 64'h100 + 64'(i);
      ibuf_q.push_back(bus.net_di);
      cycle();
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      bus.net_di = 64'h200 + 64'(i);
      bus.addr = 2'b00; bus.nicEn = 1'b1; bus.nicWrEn = 1'b0;
      #1;
      chk("wrap_ri", bus.net_ri, 64'd1);
      chk("wrap_rd", bus.d_out, ibuf_q.pop_front());
      ibuf_q.push_back(bus.net_di);
      cycle();
    end
    bus.net_si = 1'b0; bus.nicEn = 1'b0;
    proc_read(2'b01, v); chk("wrap_st01", v, 64'h0201);
    for (int i = 0; i < 2; i++) begin
      proc_read(2'b00, v); chk("wrap_tail", v, ibuf_q.pop_front());
    end

    // Reset with both FIFOs holding two packets
    bus.net_ro = 1'b0;
    bus.net_si = 1'b1;
    bus.net_di = 64'h300; cycle();
    bus.net_di = 64'h301; cycle();
    bus.net_si = 1'b0;
    proc_write(2'b10, 64'h400);
    proc_write(2'b10, 64'h401);
    proc_read(2'b01, v); chk("pre_rst_st01", v, 64'h0201);
    reset = 1'b1; bus.net_ro = 1'b1;
    #1;
    chk("mid_rst_so", bus.net_so, 64'd0);
    chk("mid_rst_ri", bus.net_ri, 64'd0);
    cycle();
    reset = 1'b0;
    #1;
    chk("post_rst_so", bus.net_so, 64'd0);
    chk("post_rst_ri", bus.net_ri, 64'd1);
    cycle();
    proc_read(2'b01, v); chk("post_rst_st01", v, 64'd0);
    proc_read(2'b11, v); chk("post_rst_st11", v, 64'd0);
    proc_read(2'b00, v); chk("post_rst_rd00", v, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
